tinyml_cam_xy_gen: RTL and testbench

Front-end coordinate generator for the camera pipeline. It converts raw sensor timing (frame-valid, line-valid, pixel-valid) plus three pixel taps into the coordinate-tagged stream (x, y, valid, data) consumed by the downstream crop/scale stages. It discards partial frames after reset, tracks frame and line statistics, and flags malformed timing.

---
 rtl/tinyml_cam_pkg.sv | 13 +
 rtl/tinyml_sync_edge.sv | 20 ++
 rtl/tinyml_cam_xy_gen.sv | 151 +++++++++++++++
 tb/tb_tinyml_cam_xy_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_cam_pkg.sv
// Shared constants and types for the camera front-end coordinate generator.
package tinyml_cam_pkg;

   localparam int CAM_COORD_W     = 11;
   localparam int CAM_FRAME_CNT_W = 8;

   typedef enum logic [1:0] {
      WAIT_LOW   = 2'd0,
      WAIT_FRAME = 2'd1,
      IN_FRAME   = 2'd2
   } cam_state_e;

endpackage

// File: rtl/tinyml_sync_edge.sv
// Registers a level signal and reports its rising and falling edges against the previous cycle.
module tinyml_sync_edge (
   input  logic in_pclk,
   input  logic in_arstn,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic prev_reg;

   always_ff @(posedge in_pclk or negedge in_arstn) begin
      if (!in_arstn) prev_reg <= 1'b0;
      else           prev_reg <= level;
   end

   assign rise = level & ~prev_reg;
   assign fall = ~level & prev_reg;

endmodule

// File: rtl/tinyml_cam_xy_gen.sv
// Turns raw sensor frame/line/pixel timing into a coordinate-tagged pixel stream
// with frame statistics and a sticky timing-error flag.
module tinyml_cam_xy_gen
   import tinyml_cam_pkg::*;
#(
   parameter int P_DEPTH = 10,
   parameter int P_X_MAX = 2047,
   parameter int P_Y_MAX = 2047
) (
   input  logic                       in_pclk,
   input  logic                       in_arstn,
   input  logic                       in_vs,
   input  logic                       in_hs,
   input  logic                       in_valid,
   input  logic [P_DEPTH-1:0]         in_data_00,
   input  logic [P_DEPTH-1:0]         in_data_01,
   input  logic [P_DEPTH-1:0]         in_data_10,
   output logic [CAM_COORD_W-1:0]     out_x,
   output logic [CAM_COORD_W-1:0]     out_y,
   output logic                       out_valid,
   output logic [P_DEPTH-1:0]         out_data_00,
   output logic [P_DEPTH-1:0]         out_data_01,
   output logic [P_DEPTH-1:0]         out_data_10,
   output logic                       out_sof,
   output logic                       out_eol,
   output logic [CAM_COORD_W-1:0]     out_line_len,
   output logic [CAM_FRAME_CNT_W-1:0] out_frame_cnt,
   output logic                       out_err
);

   // One extra bit so the counters can hold the "one past the limit" value.
   localparam int CNT_W = CAM_COORD_W + 1;
   localparam logic [CNT_W-1:0] X_LIM = CNT_W'(P_X_MAX + 1);
   localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(P_Y_MAX + 1);
   localparam int LEN_MAX_I = (2 ** CAM_COORD_W) - 1;
   localparam logic [CNT_W-1:0] LEN_SAT =
      CNT_W'(((P_X_MAX + 1) > LEN_MAX_I) ? LEN_MAX_I : (P_X_MAX + 1));

   logic vs_rise, vs_fall, hs_rise, hs_fall;

   tinyml_sync_edge u_vs_edge (
      .in_pclk  (in_pclk),
      .in_arstn (in_arstn),
      .level    (in_vs),
      .rise     (vs_rise),
      .fall     (vs_fall)
   );

   tinyml_sync_edge u_hs_edge (
      .in_pclk  (in_pclk),
      .in_arstn (in_arstn),
      .level    (in_hs),
      .rise     (hs_rise),
      .fall     (hs_fall)
   );

   cam_state_e                 state_reg, state_next;
   logic [CNT_W-1:0]           x_reg, x_next, x_cur;
   logic [CNT_W-1:0]           y_reg, y_next, y_cur;
   logic                       err_reg, err_next;
   logic                       valid_reg, sof_reg, eol_reg;
   logic [CAM_COORD_W-1:0]     x_out_reg, y_out_reg, len_reg;
   logic [P_DEPTH-1:0]         d00_reg, d01_reg, d10_reg;
   logic [CAM_FRAME_CNT_W-1:0] fcnt_reg;

   logic entering, active, pix, emit, stray, line_end, line_has_pix, frame_end;

   always_comb begin
      entering     = (state_reg == WAIT_FRAME) && vs_rise;
      active       = (state_reg == IN_FRAME) || entering;
      // The first pixel of a frame or line may arrive on the same cycle as its edge.
      x_cur        = (entering || hs_rise) ? '0 : x_reg;
      y_cur        = entering ? '0 : y_reg;
      pix          = active && in_vs && in_hs && in_valid;
      emit         = pix && (x_cur < X_LIM) && (y_cur < Y_LIM);
      stray        = active && in_vs && !in_hs && in_valid;
      // A frame ending while the line is still open also closes that line.
      line_end     = (state_reg == IN_FRAME) && (hs_fall || vs_fall);
      line_has_pix = (x_reg != '0);
      frame_end    = (state_reg == IN_FRAME) && vs_fall;

      state_next = state_reg;
      case (state_reg)
         WAIT_LOW:   if (!in_vs)   state_next = WAIT_FRAME;
         WAIT_FRAME: if (vs_rise)  state_next = IN_FRAME;
         IN_FRAME:   if (vs_fall)  state_next = WAIT_FRAME;
         default:                  state_next = WAIT_LOW;
      endcase

      x_next = x_cur;
      if (pix && (x_cur < X_LIM)) x_next = x_cur + 1'b1;
      if (line_end)               x_next = '0;

      y_next = y_cur;
      if (line_end && line_has_pix && (y_cur < Y_LIM)) y_next = y_cur + 1'b1;

      err_next = entering ? 1'b0 : err_reg;
      if ((pix && !emit) || stray) err_next = 1'b1;
   end

   always_ff @(posedge in_pclk or negedge in_arstn) begin
      if (!in_arstn) begin
         state_reg <= WAIT_LOW;
         x_reg     <= '0;
         y_reg     <= '0;
         err_reg   <= 1'b0;
         valid_reg <= 1'b0;
         sof_reg   <= 1'b0;
         eol_reg   <= 1'b0;
         x_out_reg <= '0;
         y_out_reg <= '0;
         len_reg   <= '0;
         d00_reg   <= '0;
         d01_reg   <= '0;
         d10_reg   <= '0;
         fcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         err_reg   <= err_next;
         valid_reg <= emit;
         sof_reg   <= emit && (x_cur == '0) && (y_cur == '0);
         eol_reg   <= line_end && line_has_pix;
         if (emit) begin
            x_out_reg <= x_cur[CAM_COORD_W-1:0];
            y_out_reg <= y_cur[CAM_COORD_W-1:0];
            d00_reg   <= in_data_00;
            d01_reg   <= in_data_01;
            d10_reg   <= in_data_10;
         end
         if (line_end && line_has_pix)
            len_reg <= (x_reg > LEN_SAT) ? LEN_SAT[CAM_COORD_W-1:0] : x_reg[CAM_COORD_W-1:0];
         if (frame_end)
            fcnt_reg <= fcnt_reg + 1'b1;
      end
   end

   assign out_x         = x_out_reg;
   assign out_y         = y_out_reg;
   assign out_valid     = valid_reg;
   assign out_data_00   = d00_reg;
   assign out_data_01   = d01_reg;
   assign out_data_10   = d10_reg;
   assign out_sof       = sof_reg;
   assign out_eol       = eol_reg;
   assign out_line_len  = len_reg;
   assign out_frame_cnt = fcnt_reg;
   assign out_err       = err_reg;

endmodule

// File: tb/tb_tinyml_cam_xy_gen.sv
// Directed-plus-random bench for tinyml_cam_xy_gen with a frame-level reference model.
module tb_tinyml_cam_xy_gen;

   localparam int DEPTH = 10;
   localparam int XMAX  = 3;
   localparam int YMAX  = 3;

   logic             clk = 1'b0;
   logic             arstn = 1'b1;
   logic             vs = 1'b0, hs = 1'b0, valid = 1'b0;
   logic [DEPTH-1:0] d00 = '0, d01 = '0, d10 = '0;

   logic [10:0]      out_x, out_y, out_line_len;
   logic             out_valid, out_sof, out_eol, out_err;
   logic [DEPTH-1:0] out_d00, out_d01, out_d10;
   logic [7:0]       out_frame_cnt;

   tinyml_cam_xy_gen #(
      .P_DEPTH (DEPTH),
      .P_X_MAX (XMAX),
      .P_Y_MAX (YMAX)
   ) dut (
      .in_pclk       (clk),
      .in_arstn      (arstn),
      .in_vs         (vs),
      .in_hs         (hs),
      .in_valid      (valid),
      .in_data_00    (d00),
      .in_data_01    (d01),
      .in_data_10    (d10),
      .out_x         (out_x),
      .out_y         (out_y),
      .out_valid     (out_valid),
      .out_data_00   (out_d00),
      .out_data_01   (out_d01),
      .out_data_10   (out_d10),
      .out_sof       (out_sof),
      .out_eol       (out_eol),
      .out_line_len  (out_line_len),
      .out_frame_cnt (out_frame_cnt),
      .out_err       (out_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0]      x;
      logic [10:0]      y;
      logic [DEPTH-1:0] d00;
      logic [DEPTH-1:0] d01;
      logic [DEPTH-1:0] d10;
      logic             sof;
      logic [31:0]      cyc;
   } pix_t;

   typedef struct packed {
      logic [10:0] len;
      logic [7:0]  fcnt;
      logic [31:0] cyc;
   } eol_t;

   int unsigned cyc = 0;
   int          tests = 0, fails = 0;
   int          sof_cnt = 0;
   pix_t        act_q[$], exp_q[$];
   eol_t        act_eol_q[$], exp_eol_q[$];

   // reference model: pixel position inside the current line/frame
   int m_x = 0, m_y = 0, m_frames = 0;
   bit m_err = 0, m_live = 0;
   int pat[6] = '{1, 0, 1, 1, 0, 1};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (arstn) begin
         if (out_valid)
            act_q.push_back({out_x, out_y, out_d00, out_d01, out_d10, out_sof, 32'(cyc)});
         if (out_eol)
            act_eol_q.push_back({out_line_len, out_frame_cnt, 32'(cyc)});
         if (out_sof)
            sof_cnt <= sof_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit v_s, input bit h_s, input bit v_l);
      pix_t p;
      vs = v_s; hs = h_s; valid = v_l;
      d00 = DEPTH'($urandom); d01 = DEPTH'($urandom); d10 = DEPTH'($urandom);
      if (m_live && v_s && v_l) begin
         if (h_s) begin
            if (m_x <= XMAX && m_y <= YMAX) begin
               p.x = 11'(m_x); p.y = 11'(m_y);
               p.d00 = d00; p.d01 = d01; p.d10 = d10;
               p.sof = (m_x == 0 && m_y == 0);
               p.cyc = 32'(cyc + 1);
               exp_q.push_back(p);
            end else begin
               m_err = 1;
            end
            m_x++;
         end else begin
            m_err = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic push_eol(input int c, input int fcnt);
      eol_t e;
      e.len  = 11'((m_x > XMAX + 1) ? XMAX + 1 : m_x);
      e.fcnt = 8'(fcnt);
      e.cyc  = 32'(c + 1);
      exp_eol_q.push_back(e);
   endtask

   task automatic close_line();
      int c = int'(cyc);
      step(1, 0, 0);
      if (m_live && m_x > 0) begin
         push_eol(c, m_frames);
         m_y++;
      end
      m_x = 0;
   endtask

   task automatic line(input int n, input int mode);
      int sent = 0, k = 0;
      bit v;
      if (n == 0) step(1, 1, 0);
      while (sent < n) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = 1'($urandom_range(0, 1));
            default: v = 1'(pat[k % 6]);
         endcase
         step(1, 1, v);
         if (v) sent++;
         k++;
      end
      close_line();
   endtask

   task automatic line_cut(input int n);
      int c;
      for (int i = 0; i < n; i++) step(1, 1, 1);
      c = int'(cyc);
      step(0, 1, 0);
      if (m_live && m_x > 0) push_eol(c, m_frames + 1);
      if (m_live) m_frames++;
      m_live = 0; m_x = 0;
      step(0, 0, 0);
   endtask

   task automatic frame_start(input bit gap);
      m_x = 0; m_y = 0; m_err = 0; m_live = 1;
      if (gap) step(1, 0, 0);
   endtask

   task automatic frame_end();
      step(0, 0, 0);
      if (m_live) m_frames++;
      m_live = 0;
      step(0, 0, 0);
   endtask

   task automatic compare_queues(input string tag);
      check({tag, "_npix"}, 128'(act_q.size()), 128'(exp_q.size()));
      check({tag, "_neol"}, 128'(act_eol_q.size()), 128'(exp_eol_q.size()));
      while (act_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_pix"}, 128'(act_q.pop_front()), 128'(exp_q.pop_front()));
      while (act_eol_q.size() > 0 && exp_eol_q.size() > 0)
         check({tag, "_eol"}, 128'(act_eol_q.pop_front()), 128'(exp_eol_q.pop_front()));
      act_q.delete(); exp_q.delete(); act_eol_q.delete(); exp_eol_q.delete();
   endtask

   task automatic check_frame(input string tag);
      step(0, 0, 0);
      step(0, 0, 0);
      compare_queues(tag);
      check({tag, "_fcnt"}, 128'(out_frame_cnt), 128'(8'(m_frames)));
      check({tag, "_err"}, 128'(out_err), 128'(m_err));
   endtask

   initial begin
      int sof_base;

      // reset asserted while the sensor is mid-frame
      #1 arstn = 1'b0; vs = 1'b1; hs = 1'b1; valid = 1'b1;
      @(negedge clk);
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_x", 128'(out_x), 128'(0));
      check("rst_y", 128'(out_y), 128'(0));
      check("rst_sof", 128'(out_sof), 128'(0));
      check("rst_eol", 128'(out_eol), 128'(0));
      check("rst_len", 128'(out_line_len), 128'(0));
      check("rst_fcnt", 128'(out_frame_cnt), 128'(0));
      check("rst_err", 128'(out_err), 128'(0));
      check("rst_d00", 128'(out_d00), 128'(0));
      arstn = 1'b1;

      // remainder of the interrupted frame must be discarded
      m_live = 0;
      step(1, 1, 1); step(1, 1, 1); step(1, 1, 1);
      close_line();
      line(4, 0);
      frame_end();

      sof_base = sof_cnt;
      frame_start(1);
      repeat (3) line(4, 0);
      frame_end();
      check_frame("f4x3");
      check("f4x3_sof", 128'(sof_cnt - sof_base), 128'(1));

      frame_start(1);
      repeat (3) line(4, 2);
      frame_end();
      check_frame("gaps");

      // x overflow, then the next frame start clears the error
      frame_start(0);
      line(6, 0);
      line(4, 1);
      frame_end();
      check_frame("xovf");
      frame_start(1);
      check("err_clr", 128'(out_err), 128'(0));

      // stray pixel while line-valid is low
      line(2, 0);
      step(1, 0, 1);
      line(3, 0);
      frame_end();
      check_frame("stray");

      // frame valid drops while line valid is still high
      frame_start(1);
      line(4, 0);
      line_cut(2);
      check_frame("vscut");

      // line valid toggling outside a frame is ignored
      step(0, 1, 1); step(0, 1, 1); step(0, 0, 1);
      check_frame("hs_idle");

      // y overflow with the first pixel on the frame-valid edge
      frame_start(0);
      repeat (5) line(3, 0);
      frame_end();
      check_frame("yovf");

      for (int f = 0; f < 6; f++) begin
         frame_start(1'($urandom_range(0, 1)));
         for (int l = 0; l < int'($urandom_range(1, 5)); l++)
            line(int'($urandom_range(0, 6)), 1);
         frame_end();
         check_frame("rand");
      end

      // reset mid-frame: outputs clear at once, the rest of the frame is dropped
      frame_start(1);
      line(3, 0);
      step(1, 1, 1); step(1, 1, 1);
      #2 arstn = 1'b0;
      #1;
      check("mrst_valid", 128'(out_valid), 128'(0));
      check("mrst_x", 128'(out_x), 128'(0));
      check("mrst_len", 128'(out_line_len), 128'(0));
      check("mrst_fcnt", 128'(out_frame_cnt), 128'(0));
      compare_queues("pre_rst");
      m_frames = 0; m_err = 0; m_live = 0; m_x = 0; m_y = 0;
      @(negedge clk);
      arstn = 1'b1;
      line(2, 0);
      frame_end();

      sof_base = sof_cnt;
      for (int f = 0; f < 256; f++) begin
         frame_start(1);
         line(1, 0);
         frame_end();
      end
      check_frame("wrap");
      check("wrap_sof", 128'(sof_cnt - sof_base), 128'(256));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
